// File: rtl/async_rx.sv
// 8N1 asynchronous serial receiver: 2-FF synchronizer, start-edge bit timing from a
// bit-period counter, LSB-first shift register and a registered byte/valid/error output stage.
module async_rx #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd5208,
    parameter int          WIDTH        = 16,
    parameter int          DATA_BITS    = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int               C_INT  = int'(CLKS_PER_BIT);
    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(C_INT - 1);
    localparam logic [WIDTH-1:0] H_LAST = WIDTH'(C_INT / 2 - 1);
    localparam int               IDX_W  = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [DATA_BITS-1:0]   shift;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic                   done;
    logic                   done_ok;

    // NOTE: the synchronizer resets to 1 (idle line) so leaving reset never looks like a start bit.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    assign rx_s = sync_q[1];

    // NOTE: every state register here uses <=, so all branches read the pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            done       <= 1'b0;
            done_ok    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else if (!en) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            done       <= 1'b0;

            // Output stage: publishes the frame sampled in STOP on the previous cycle.
            if (done) begin
                if (done_ok) begin
                    data_out   <= shift;
                    data_valid <= 1'b1;
                    frame_err  <= 1'b0;
                end else begin
                    frame_err  <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == H_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                            idx   <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == C_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == C_LAST) begin
                        cnt     <= '0;
                        done    <= 1'b1;
                        done_ok <= rx_s;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
